// File: rtl/pa_clint_pkg.sv
// Shared CLINT definitions: register offsets, reset constants and the address decoder.
package pa_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        RegNone,
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi
    } clint_reg_e;

    // Word accesses only: the byte-lane bits never take part in the match.
    function automatic clint_reg_e clint_decode(input logic [15:0] addr);
        logic [13:0] word;
        word = addr[15:2];
        if (word == CLINT_MSIP_OFS[15:2]) begin
            return RegMsip;
        end else if (word == CLINT_MTIMECMP_LO_OFS[15:2]) begin
            return RegCmpLo;
        end else if (word == CLINT_MTIMECMP_HI_OFS[15:2]) begin
            return RegCmpHi;
        end else if (word == CLINT_MTIME_LO_OFS[15:2]) begin
            return RegTimeLo;
        end else if (word == CLINT_MTIME_HI_OFS[15:2]) begin
            return RegTimeHi;
        end
        return RegNone;
    endfunction

endpackage

// File: rtl/pa_clint_mtime_cnt.sv
// 64-bit mtime counter: ticks when enabled outside debug, half-word writes take priority.
module pa_clint_mtime_cnt (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        tick,
    input  logic        dbgon,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtime_next
);

    logic [63:0] mtime_q;

    always_comb begin
        mtime_next = mtime_q;
        if (wr_lo) begin
            mtime_next[31:0] = wdata;
        end else if (wr_hi) begin
            mtime_next[63:32] = wdata;
        end else if (tick && !dbgon) begin
            mtime_next = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mtime_q <= 64'd0;
        end else begin
            mtime_q <= mtime_next;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/pa_clint_tcip_slave.sv
// CLINT register responder on the TCIP lane: msip, mtimecmp, mtime and the M-mode interrupt lines.
module pa_clint_tcip_slave
    import pa_clint_pkg::*;
(
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        tcipif_clint_sel,
    input  logic [15:0] tcipif_xx_addr,
    input  logic [31:0] tcipif_xx_wdata,
    input  logic        tcipif_xx_write,
    input  logic        sysio_clint_tick,
    input  logic        rtu_yy_xx_dbgon,
    output logic        clint_tcipif_cmplt,
    output logic [31:0] clint_tcipif_rdata,
    output logic        clint_cpu_me_int,
    output logic        clint_cpu_ms_int
);

    logic        cmplt_q;
    logic [31:0] rdata_q;
    logic        me_int_q;
    logic        msip_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_next;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [31:0] rd_val;
    logic        accept;
    logic        wr_en;
    clint_reg_e  reg_sel;

    // The bridge keeps sel high through the completion cycle, so that cycle is never an accept.
    assign accept  = tcipif_clint_sel && !cmplt_q;
    assign wr_en   = accept && tcipif_xx_write;
    assign reg_sel = clint_decode(tcipif_xx_addr);

    pa_clint_mtime_cnt u_mtime_cnt (
        .clk        (forever_cpuclk),
        .rst_b      (cpurst_b),
        .tick       (sysio_clint_tick),
        .dbgon      (rtu_yy_xx_dbgon),
        .wr_lo      (wr_en && (reg_sel == RegTimeLo)),
        .wr_hi      (wr_en && (reg_sel == RegTimeHi)),
        .wdata      (tcipif_xx_wdata),
        .mtime      (mtime),
        .mtime_next (mtime_next)
    );

    always_comb begin
        mtimecmp_next = mtimecmp_q;
        if (wr_en && (reg_sel == RegCmpLo)) begin
            mtimecmp_next[31:0] = tcipif_xx_wdata;
        end else if (wr_en && (reg_sel == RegCmpHi)) begin
            mtimecmp_next[63:32] = tcipif_xx_wdata;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            RegMsip:   rd_val = {31'd0, msip_q};
            RegCmpLo:  rd_val = mtimecmp_q[31:0];
            RegCmpHi:  rd_val = mtimecmp_q[63:32];
            RegTimeLo: rd_val = mtime[31:0];
            RegTimeHi: rd_val = mtime[63:32];
            default:   rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cmplt_q    <= 1'b0;
            rdata_q    <= 32'd0;
            me_int_q   <= 1'b0;
            msip_q     <= 1'b0;
            mtimecmp_q <= CLINT_MTIMECMP_RST;
        end else begin
            cmplt_q    <= accept;
            rdata_q    <= (accept && !tcipif_xx_write) ? rd_val : 32'd0;
            mtimecmp_q <= mtimecmp_next;
            // Compare next-state values so a write shows on the line together with cmplt.
            me_int_q   <= (mtime_next >= mtimecmp_next);
            if (wr_en && (reg_sel == RegMsip)) begin
                msip_q <= tcipif_xx_wdata[0];
            end
        end
    end

    assign clint_tcipif_cmplt = cmplt_q;
    assign clint_tcipif_rdata = rdata_q;
    assign clint_cpu_me_int   = me_int_q;
    assign clint_cpu_ms_int   = msip_q;

endmodule

// File: tb/tb_pa_clint_tcip_slave.sv
// Self-checking bench for pa_clint_tcip_slave against a cycle-level register model.
module tb_pa_clint_tcip_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic        write = 1'b0;
    logic        tick = 1'b0;
    logic        dbg = 1'b0;
    logic        cmplt;
    logic [31:0] rdata;
    logic        me_int;
    logic        ms_int;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [63:0] m_time = 64'd0;
    logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_msip = 1'b0;
    logic        m_cmplt = 1'b0;
    logic        m_me = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    pa_clint_tcip_slave dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .tcipif_clint_sel   (sel),
        .tcipif_xx_addr     (addr),
        .tcipif_xx_wdata    (wdata),
        .tcipif_xx_write    (write),
        .sysio_clint_tick   (tick),
        .rtu_yy_xx_dbgon    (dbg),
        .clint_tcipif_cmplt (cmplt),
        .clint_tcipif_rdata (rdata),
        .clint_cpu_me_int   (me_int),
        .clint_cpu_ms_int   (ms_int)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[31:0];
            16'hBFFC: return m_time[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_time = 64'd0;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip = 1'b0;
        m_cmplt = 1'b0;
        m_me = 1'b0;
        m_rdata = 32'd0;
    endtask

    // One clock: model evaluates the current inputs, then DUT outputs settle at edge + 1.
    task automatic cycle();
        logic        acc;
        logic [15:0] w;
        logic [63:0] t;
        logic [63:0] c;
        logic        ms;
        logic [31:0] rd;
        acc = sel && !m_cmplt;
        w = addr & 16'hFFFC;
        t = m_time;
        c = m_cmp;
        ms = m_msip;
        rd = 32'd0;
        if (acc && !write) rd = m_read(addr);
        if (acc && write && w == 16'hBFF8) t = {m_time[63:32], wdata};
        else if (acc && write && w == 16'hBFFC) t = {wdata, m_time[31:0]};
        else if (tick && !dbg) t = m_time + 64'd1;
        if (acc && write && w == 16'h4000) c = {m_cmp[63:32], wdata};
        if (acc && write && w == 16'h4004) c = {wdata, m_cmp[31:0]};
        if (acc && write && w == 16'h0000) ms = wdata[0];
        @(posedge clk);
        #1;
        m_time = t;
        m_cmp = c;
        m_msip = ms;
        m_cmplt = acc;
        m_rdata = rd;
        m_me = (t >= c);
    endtask

    // Bridge-style access: hold sel until cmplt (bounded), then let the completion cycle end.
    task automatic access(input logic [15:0] a, input logic wr, input logic [31:0] d,
                          output logic [31:0] rd, output int lat,
                          output logic me_c, output logic ms_c);
        addr = a;
        write = wr;
        wdata = d;
        sel = 1'b1;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!cmplt && lat < 4);
        rd = rdata;
        me_c = me_int;
        ms_c = ms_int;
        sel = 1'b0;
        write = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        total++; if (cmplt !== 1'b0) begin bad++; $display("FAIL reset_cmplt got=%b exp=0", cmplt); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (me_int !== 1'b0) begin bad++; $display("FAIL reset_me got=%b exp=0", me_int); end
        total++; if (ms_int !== 1'b0) begin bad++; $display("FAIL reset_ms got=%b exp=0", ms_int); end
        access(16'hBFF8, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL read_latency got=%0d exp=1", lat); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_mtime_lo got=%h exp=0", rd); end
        access(16'h4004, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp_hi got=%h exp=ffffffff", rd); end
        total++; if (mc !== 1'b0) begin bad++; $display("FAIL reset_me_after got=%b exp=0", mc); end
    endtask

    task automatic test_msip();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        access(16'h0000, 1'b1, 32'h3, rd, lat, mc, sc);
        total++; if (sc !== 1'b1) begin bad++; $display("FAIL msip_set got=%b exp=1", sc); end
        access(16'h0000, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL msip_read got=%h exp=1", rd); end
        access(16'h0000, 1'b1, 32'h0, rd, lat, mc, sc);
        total++; if (sc !== 1'b0) begin bad++; $display("FAIL msip_clear got=%b exp=0", sc); end
    endtask

    task automatic test_carry();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        access(16'hBFF8, 1'b1, 32'hFFFF_FFFF, rd, lat, mc, sc);
        access(16'hBFFC, 1'b1, 32'h0, rd, lat, mc, sc);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        access(16'hBFFC, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL carry_hi got=%h exp=1", rd); end
        access(16'hBFF8, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL carry_lo got=%h exp=0", rd); end
        dbg = 1'b1;
        tick = 1'b1;
        repeat (5) cycle();
        tick = 1'b0;
        dbg = 1'b0;
        access(16'hBFF8, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL dbg_freeze_lo got=%h exp=0", rd); end
        access(16'hBFFC, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL dbg_freeze_hi got=%h exp=1", rd); end
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        access(16'h4000, 1'b1, 32'h10, rd, lat, mc, sc);
        access(16'h4004, 1'b1, 32'h0, rd, lat, mc, sc);
        access(16'hBFFC, 1'b1, 32'h0, rd, lat, mc, sc);
        access(16'hBFF8, 1'b1, 32'h0F, rd, lat, mc, sc);
        total++; if (me_int !== 1'b0) begin bad++; $display("FAIL me_below got=%b exp=0", me_int); end
        tick = 1'b1;
        cycle();
        total++; if (me_int !== 1'b1) begin bad++; $display("FAIL me_rise got=%b exp=1", me_int); end
        tick = 1'b0;
        access(16'h4004, 1'b1, 32'h1, rd, lat, mc, sc);
        total++; if (mc !== 1'b0) begin bad++; $display("FAIL me_fall got=%b exp=0", mc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        int pulses;
        logic prev;
        pulses = 0;
        prev = 1'b0;
        addr = 16'hBFF8;
        write = 1'b0;
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (cmplt !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL b2b_cmplt[%0d] got=%b exp=%b", i, cmplt, (i % 2) == 0);
            end
            if (cmplt === 1'b1 && prev === 1'b1) begin
                bad++;
                $display("FAIL b2b_adjacent[%0d] got=1 exp=0", i);
            end
            if (cmplt === 1'b1) pulses++;
            prev = cmplt;
        end
        sel = 1'b0;
        cycle();
        total++; if (pulses != 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        access(16'h1234, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL unmapped_cmplt got=%0d exp=1", lat); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_write_tick();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        addr = 16'hBFF8;
        wdata = 32'h1234_5678;
        write = 1'b1;
        sel = 1'b1;
        tick = 1'b1;
        cycle();
        sel = 1'b0;
        write = 1'b0;
        tick = 1'b0;
        cycle();
        access(16'hBFF8, 1'b0, 32'd0, rd, lat, mc, sc);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL write_wins got=%h exp=12345678", rd); end
    endtask

    task automatic test_random();
        int pick;
        for (int i = 0; i < 400; i++) begin
            sel = ($urandom_range(0, 2) != 0);
            write = $urandom_range(0, 1);
            pick = $urandom_range(0, 5);
            case (pick)
                0: addr = 16'h0000;
                1: addr = 16'h4000;
                2: addr = 16'h4004;
                3: addr = 16'hBFF8;
                4: addr = 16'hBFFC;
                default: addr = $urandom;
            endcase
            addr[1:0] = $urandom_range(0, 3);
            wdata = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 40);
            tick = $urandom_range(0, 1);
            dbg = ($urandom_range(0, 4) == 0);
            cycle();
            total++; if (cmplt !== m_cmplt) begin bad++; $display("FAIL rnd_cmplt[%0d] got=%b exp=%b", i, cmplt, m_cmplt); end
            total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, rdata, m_rdata); end
            total++; if (me_int !== m_me) begin bad++; $display("FAIL rnd_me[%0d] got=%b exp=%b", i, me_int, m_me); end
            total++; if (ms_int !== m_msip) begin bad++; $display("FAIL rnd_ms[%0d] got=%b exp=%b", i, ms_int, m_msip); end
        end
        sel = 1'b0;
        write = 1'b0;
        tick = 1'b0;
        dbg = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        logic mc, sc;
        access(16'h0000, 1'b1, 32'h1, rd, lat, mc, sc);
        access(16'h4004, 1'b1, 32'h0, rd, lat, mc, sc);
        access(16'h4000, 1'b1, 32'h0, rd, lat, mc, sc);
        addr = 16'h4000;
        write = 1'b0;
        sel = 1'b1;
        cycle();
        total++; if (cmplt !== 1'b1) begin bad++; $display("FAIL mid_cmplt_pre got=%b exp=1", cmplt); end
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (cmplt !== 1'b0) begin bad++; $display("FAIL mid_cmplt got=%b exp=0", cmplt); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        total++; if (me_int !== 1'b0) begin bad++; $display("FAIL mid_me got=%b exp=0", me_int); end
        total++; if (ms_int !== 1'b0) begin bad++; $display("FAIL mid_ms got=%b exp=0", ms_int); end
        sel = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_msip();
        test_carry();
        test_timer();
        test_back_to_back();
        test_write_tick();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
